// File: rtl/gray_to_bin_sync.sv
// Synchronizes an asynchronous Gray-coded count, converts it to binary and
// classifies each change as a legal +1/-1 step or an error, counting errors.
module gray_to_bin_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             up_pulse,
  output logic             dn_pulse,
  output logic             err_pulse,
  output logic [7:0]       err_cnt
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] pb_inc;
  logic [WIDTH-1:0] pb_dec;

  always_comb begin
    sync1_d = gray_in;
    sync2_d = sync1_q;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    nb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nb[i] = ^(sync2_q >> i);
    end

    pb_inc = bin_q + WIDTH'(1);
    pb_dec = bin_q - WIDTH'(1);

    bin_d = nb;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    err_d = 1'b0;
    if (nb == pb_inc) begin
      up_d = 1'b1;
    end else if (nb == pb_dec) begin
      dn_d = 1'b1;
    end else if (nb != bin_q) begin
      err_d = 1'b1;
    end

    // Counts the registered error pulse, so a clear in the pulse cycle wins.
    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = 8'd0;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      bin_q     <= '0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      bin_q     <= bin_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bin_out   = bin_q;
  assign up_pulse  = up_q;
  assign dn_pulse  = dn_q;
  assign err_pulse = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_to_bin_sync.sv
// Directed self-checking bench for gray_to_bin_sync at WIDTH=4.
module tb_gray_to_bin_sync;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       up_pulse;
  logic       dn_pulse;
  logic       err_pulse;
  logic [7:0] err_cnt;

  int n_checks;
  int n_fail;
  int up_n;
  int dn_n;
  int err_n;
  logic [3:0] exp_bin;

  gray_to_bin_sync #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .clr_err   (clr_err),
    .bin_out   (bin_out),
    .up_pulse  (up_pulse),
    .dn_pulse  (dn_pulse),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns after it, tallying pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    up_n  += int'(up_pulse);
    dn_n  += int'(dn_pulse);
    err_n += int'(err_pulse);
  endtask

  task automatic clr_counts();
    up_n  = 0;
    dn_n  = 0;
    err_n = 0;
  endtask

  // Drive a new Gray value, check 3-edge latency, the pulse kind and that
  // exactly one pulse results over a 10-cycle hold.
  task automatic apply(input logic [3:0] g, input logic [3:0] eb,
                       input logic [2:0] ep, input string tag);
    gray_in = g;
    clr_counts();
    tick();
    tick();
    chk({tag, "_latency"}, 32'(bin_out), 32'(exp_bin));
    tick();
    chk({tag, "_bin"}, 32'(bin_out), 32'(eb));
    chk({tag, "_pulse"}, 32'({up_pulse, dn_pulse, err_pulse}), 32'(ep));
    repeat (7) tick();
    chk({tag, "_count"}, {8'd0, 8'(up_n), 8'(dn_n), 8'(err_n)},
        {8'd0, 8'(ep[2]), 8'(ep[1]), 8'(ep[0])});
    chk({tag, "_hold"}, 32'(bin_out), 32'(eb));
    exp_bin = eb;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_bin  = 4'd0;
    clr_counts();
    rst_n    = 1'b0;
    gray_in  = 4'b0000;
    clr_err  = 1'b0;

    repeat (3) tick();
    chk("reset_outputs", {19'd0, bin_out, up_pulse, dn_pulse, err_pulse, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Count up 0..4
    apply(4'b0001, 4'd1, 3'b100, "up_1");
    apply(4'b0011, 4'd2, 3'b100, "up_2");
    apply(4'b0010, 4'd3, 3'b100, "up_3");
    apply(4'b0110, 4'd4, 3'b100, "up_4");
    chk("up_err_cnt", 32'(err_cnt), 32'd0);

    // 4 -> 15 is an illegal jump, then wrap up and back down
    apply(4'b1000, 4'd15, 3'b001, "jump_15");
    chk("jump_err_cnt", 32'(err_cnt), 32'd1);
    apply(4'b0000, 4'd0, 3'b100, "wrap_up");
    apply(4'b1000, 4'd15, 3'b010, "wrap_dn");
    chk("wrap_err_cnt", 32'(err_cnt), 32'd1);

    // Error from bin_out = 0 to 2
    apply(4'b0000, 4'd0, 3'b100, "back_0");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    apply(4'b0011, 4'd2, 3'b001, "err_jump");
    chk("err_jump_cnt", 32'(err_cnt), 32'd1);

    // Saturation: 260 alternating jumps between bin 2 and bin 0
    clr_counts();
    for (int k = 0; k < 260; k++) begin
      gray_in = (k % 2 == 0) ? 4'b0000 : 4'b0011;
      repeat (3) tick();
    end
    repeat (3) tick();
    chk("sat_err_pulses", 32'(err_n), 32'd260);
    chk("sat_up_dn", 32'(up_n + dn_n), 32'd0);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    repeat (5) tick();
    chk("sat_hold", 32'(err_cnt), 32'd255);

    // Clear in the same cycle as an error pulse
    gray_in = 4'b0000;
    repeat (3) tick();
    chk("coincide_pulse", 32'(err_pulse), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("coincide_clr", 32'(err_cnt), 32'd0);
    tick();
    chk("coincide_after", 32'(err_cnt), 32'd0);
    exp_bin = 4'd0;

    // Hold constant for 50 cycles
    clr_counts();
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bin_out !== 4'd0) err_n += 100;
    end
    chk("hold_quiet", {8'd0, 8'(up_n), 8'(dn_n), 8'(err_n)}, 32'd0);

    // Reset mid-operation with data in flight
    apply(4'b0011, 4'd2, 3'b001, "pre_rst");
    gray_in = 4'b0111;
    tick();
    gray_in = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {19'd0, bin_out, up_pulse, dn_pulse, err_pulse, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_counts();
    tick();
    chk("rel_edge1", 32'({bin_out, up_pulse, dn_pulse, err_pulse}), 32'd0);
    tick();
    chk("rel_edge2", 32'({bin_out, up_pulse, dn_pulse, err_pulse}), 32'd0);
    tick();
    chk("rel_edge3", 32'({bin_out, up_pulse, dn_pulse, err_pulse}), 32'({4'd1, 3'b100}));
    repeat (5) tick();
    chk("rel_count", {8'd0, 8'(up_n), 8'(dn_n), 8'(err_n)}, {8'd0, 8'd1, 8'd0, 8'd0});
    chk("rel_err_cnt", 32'(err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
